led_frame_streamer: RTL and testbench
=====================================

// Module: led_frame_streamer
// PURPOSE
//  Consumer end of the visualizer output interface: captures one frame of per-bin colors
//  (rgb) and LED counts (LEDCounts) on start (the visualizer's data_v) and expands it into
//  an ordered stream of exactly LEDS pixels over a valid/ready handshake.
//  Bin 0 pixels first, then bin 1, etc.; black padding when counts sum < LEDS; truncation
//  when they exceed LEDS. Feeds the LED-strip line driver.
// PARAMETERS
//  LEDS     50  number of LEDs per frame (pixels emitted per frame)
//  BIN_QTY  12  number of color bins per frame
//  CW       $clog2(LEDS)  width of each LED count (localparam, not overridable)
// PORTS
//  clk          in   1               clock; all state on posedge
//  rst          in   1               reset, asynchronous, active-high
//  rgb          in   BIN_QTY x 24    per-bin color {R[23:16],G[15:8],B[7:0]}, sampled on start
//  LEDCounts    in   BIN_QTY x CW    per-bin LED count, sampled on start
//  start        in   1               frame available; sampled only in IDLE
//  pixel_o      out  24              current pixel color
//  pixel_v      out  1               pixel_o valid
//  pixel_ready  in   1               downstream accepts pixel when pixel_v && pixel_ready
//  pixel_last   out  1               high with pixel_v on pixel index LEDS-1
//  frame_done   out  1               one-cycle pulse after last pixel accepted
//  busy         out  1               high from start capture until frame_done cycle inclusive
// BEHAVIOUR
//  Reset (async, immediate): state IDLE; pixel_o=0, pixel_v=0, pixel_last=0, frame_done=0,
//   busy=0; captured rgb/counts, bin pointer, remaining count, pixel counter cleared.
//  FSM IDLE -> STREAM -> PAD -> DONE -> IDLE.
//   IDLE: start=1 at edge N: register all rgb/LEDCounts, busy=1, pixel counter=0, bin
//    pointer = lowest bin with nonzero count (priority search); none -> PAD, else STREAM.
//    First pixel_v=1 in cycle N+1 (latency 1).
//   STREAM: pixel_o = captured rgb[bin]; each accepted pixel decrements bin remaining count
//    and increments pixel counter. When remaining reaches 0, jump to next higher bin with
//    nonzero count in the same cycle (no bubble; zero-count bins consume no cycles).
//    No further nonzero bin -> PAD.
//   PAD: pixel_o = 24'h000000 until pixel counter reaches LEDS.
//   Either state: acceptance of pixel index LEDS-1 (pixel_last=1) -> DONE regardless of
//    remaining bins (truncation; remaining counts discarded).
//   DONE: pixel_v=0, frame_done=1 for exactly one cycle, busy=1; -> IDLE (busy=0 next).
//  Handshake: pixel_o, pixel_last held stable while pixel_v && !pixel_ready; pixel_v never
//   drops until acceptance. pixel_ready while pixel_v=0 has no effect. Back-to-back
//   acceptance gives one pixel per cycle.
//  start while busy (STREAM/PAD/DONE) ignored, not queued; inputs not resampled.
//   start in IDLE the cycle after DONE begins a new frame normally.
//  Exactly LEDS pixels per frame; pixel counter width $clog2(LEDS+1), never wraps.
//  Count sum may reach BIN_QTY*(2^CW-1); no sum computed, truncation is by pixel counter.
//  Counts > LEDS in a single bin legal: that bin fills remainder of frame.
//  Reset mid-frame: frame abandoned, no frame_done, outputs to reset values immediately.
// TESTING
//  1 All counts 0, start -> 50 pixels of 000000, pixel_last on 50th, frame_done next cycle.
//  2 cnt[0]=10 rgb FF0000, cnt[3]=5 rgb 00FF00, others 0, ready=1 -> 10 red, 5 green,
//    35 black, contiguous cycles N+1..N+50, frame_done at N+51.
//  3 All cnt=5 (sum 60) -> bins 0..9 five pixels each, bins 10,11 never output; last=pixel 50.
//  4 Case 2 with random 50% pixel_ready -> identical accepted sequence; pixel_o/pixel_last
//    stable through every stall; still exactly 50 accepts.
//  5 Second start with new data at pixel 20 -> ignored; frame matches first capture;
//    start right after frame_done -> new frame with new data.
//  6 rst asserted mid-frame (pixel 20, between edges) -> all outputs 0 before next edge,
//    no frame_done; later start -> full correct 50-pixel frame.

Source files
------------

// File: rtl/led_frame_streamer.sv
// led_frame_streamer: captures one frame of per-bin colors and LED counts,
// then streams exactly LEDS pixels over a valid/ready handshake.
// Bins are emitted in ascending order. The frame is padded with black when
// the counts fall short of LEDS, and truncated when they exceed it.
module led_frame_streamer #(
  parameter  int LEDS    = 50,
  parameter  int BIN_QTY = 12,
  localparam int CW      = $clog2(LEDS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BIN_QTY-1:0][23:0]     rgb,
  input  logic [BIN_QTY-1:0][CW-1:0]   LEDCounts,
  input  logic                         start,
  output logic [23:0]                  pixel_o,
  output logic                         pixel_v,
  input  logic                         pixel_ready,
  output logic                         pixel_last,
  output logic                         frame_done,
  output logic                         busy
);

  localparam int PW = $clog2(LEDS + 1);
  localparam int BW = (BIN_QTY > 1) ? $clog2(BIN_QTY) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(LEDS - 1);

  typedef enum logic [1:0] {IDLE, STREAM, PAD, DONE} state_t;

  state_t                       state_q, state_d;
  logic [BIN_QTY-1:0][23:0]     rgb_q;
  logic [BIN_QTY-1:0][CW-1:0]   counts_q;
  logic [BW-1:0]                bin_q, bin_d;
  logic [CW-1:0]                rem_q, rem_d;
  logic [PW-1:0]                pix_q, pix_d;
  logic                         capture;
  logic                         accept;

  // Priority search: the lowest bin at or above 'from' that has a nonzero count.
  // The result is {found, index}.
  function automatic logic [BW:0] next_bin(input logic [BIN_QTY-1:0][CW-1:0] counts,
                                           input int from);
    logic          found;
    logic [BW-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int i = BIN_QTY - 1; i >= 0; i--) begin
      if (i >= from && counts[i] != '0) begin
        found = 1'b1;
        idx   = BW'(i);
      end
    end
    return {found, idx};
  endfunction

  logic [BW:0] first_sel, next_sel;
  assign first_sel = next_bin(LEDCounts, 0);
  assign next_sel  = next_bin(counts_q, int'(bin_q) + 1);

  // Outputs are decoded from registered state, so an async reset clears them at once.
  assign pixel_v    = (state_q == STREAM) || (state_q == PAD);
  assign pixel_o    = (state_q == STREAM) ? rgb_q[bin_q] : 24'h000000;
  assign pixel_last = pixel_v && (pix_q == LAST_IDX);
  assign frame_done = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign accept     = pixel_v && pixel_ready;

  // State register plus pixel bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      rem_q   <= '0;
      pix_q   <= '0;
    end else begin
      // NOTE: use non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      bin_q   <= bin_d;
      rem_q   <= rem_d;
      pix_q   <= pix_d;
    end
  end

  // Frame capture. Inputs are sampled only when a start is taken in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the captured frame is cleared on reset so that no stale colors survive it.
      rgb_q    <= '0;
      counts_q <= '0;
    end else if (capture) begin
      rgb_q    <= rgb;
      counts_q <= LEDCounts;
    end
  end

  // Next-state logic: bin walking without bubbles, padding, and truncation on the last pixel.
  always_comb begin
    // NOTE: defaults come first so that every path assigns every signal and no latch is inferred.
    state_d = state_q;
    bin_d   = bin_q;
    rem_d   = rem_q;
    pix_d   = pix_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          pix_d   = '0;
          if (first_sel[BW]) begin
            state_d = STREAM;
            bin_d   = first_sel[BW-1:0];
            rem_d   = LEDCounts[first_sel[BW-1:0]];
          end else begin
            state_d = PAD;
            bin_d   = '0;
            rem_d   = '0;
          end
        end
      end
      STREAM: begin
        if (accept) begin
          pix_d = pix_q + 1'b1;
          if (pixel_last) begin
            state_d = DONE;
          end else if (rem_q == CW'(1)) begin
            if (next_sel[BW]) begin
              bin_d = next_sel[BW-1:0];
              rem_d = counts_q[next_sel[BW-1:0]];
            end else begin
              state_d = PAD;
              rem_d   = '0;
            end
          end else begin
            rem_d = rem_q - 1'b1;
          end
        end
      end
      PAD: begin
        if (accept) begin
          pix_d = pix_q + 1'b1;
          if (pixel_last) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_led_frame_streamer.sv
// Testbench for led_frame_streamer. A frame-level model expands bins into the
// expected 50-pixel sequence, and each accepted pixel is compared against it.
module tb_led_frame_streamer;

  localparam int LEDS    = 50;
  localparam int BIN_QTY = 12;
  localparam int CW      = $clog2(LEDS);

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic [BIN_QTY-1:0][23:0]    rgb = '0;
  logic [BIN_QTY-1:0][CW-1:0]  led_counts = '0;
  logic                        start = 1'b0;
  logic [23:0]                 pixel_o;
  logic                        pixel_v;
  logic                        pixel_ready = 1'b0;
  logic                        pixel_last;
  logic                        frame_done;
  logic                        busy;

  int total = 0;
  int bad   = 0;

  // Reference frame content and the expected pixel stream derived from it.
  logic [23:0] m_rgb[BIN_QTY];
  int          m_cnt[BIN_QTY];
  logic [23:0] exp_pix[LEDS];

  led_frame_streamer #(.LEDS(LEDS), .BIN_QTY(BIN_QTY)) dut (
    .clk        (clk),
    .rst        (rst),
    .rgb        (rgb),
    .LEDCounts  (led_counts),
    .start      (start),
    .pixel_o    (pixel_o),
    .pixel_v    (pixel_v),
    .pixel_ready(pixel_ready),
    .pixel_last (pixel_last),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Model: lay bins out in order, cut the stream at LEDS, and fill the rest with black.
  function automatic void build_expected();
    int k;
    k = 0;
    for (int b = 0; b < BIN_QTY; b++)
      for (int j = 0; j < m_cnt[b]; j++)
        if (k < LEDS) begin
          exp_pix[k] = m_rgb[b];
          k++;
        end
    while (k < LEDS) begin
      exp_pix[k] = 24'h000000;
      k++;
    end
  endfunction

  function automatic void random_frame();
    for (int b = 0; b < BIN_QTY; b++) begin
      m_rgb[b] = 24'($urandom);
      if ($urandom_range(0, 9) == 0)      m_cnt[b] = 63;
      else if ($urandom_range(0, 2) == 0) m_cnt[b] = 0;
      else                                m_cnt[b] = $urandom_range(1, 9);
    end
  endfunction

  // Entered and left at posedge+1: loads the inputs, pulses start, and checks first-pixel latency.
  task automatic start_frame(input string name);
    build_expected();
    for (int b = 0; b < BIN_QTY; b++) begin
      rgb[b]        = m_rgb[b];
      led_counts[b] = CW'(m_cnt[b]);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if ({pixel_v, busy, frame_done} !== 3'b110) begin
      bad++;
      $display("FAIL %s latency: {v,busy,done}=%b want 110", name, {pixel_v, busy, frame_done});
    end
  endtask

  // Accepts a whole frame with random ready. It checks data, last, stall stability and the done pulse.
  // When poke_at >= 0, a start with scrambled inputs is raised at that pixel index.
  task automatic collect(input string name, input int ready_pct, input int poke_at);
    int          got = 0;
    int          cycles = 0;
    logic        stalled = 1'b0;
    logic        poked = 1'b0;
    logic [23:0] held_o = '0;
    logic        held_last = 1'b0;
    logic        want_last;
    while (got < LEDS && cycles < 1000) begin
      start = 1'b0;
      if (poke_at >= 0 && got == poke_at && !poked) begin
        poked = 1'b1;
        start = 1'b1;
        for (int b = 0; b < BIN_QTY; b++) begin
          rgb[b]        = 24'($urandom);
          led_counts[b] = CW'($urandom);
        end
      end
      pixel_ready = ($urandom_range(0, 99) < ready_pct);
      total++;
      if (pixel_v !== 1'b1) begin
        bad++;
        $display("FAIL %s valid at pixel %0d: got %b want 1", name, got, pixel_v);
        break;
      end
      if (stalled) begin
        total++;
        if ({pixel_o, pixel_last} !== {held_o, held_last}) begin
          bad++;
          $display("FAIL %s stall hold at pixel %0d: got %h/%b want %h/%b",
                   name, got, pixel_o, pixel_last, held_o, held_last);
        end
      end
      if (pixel_ready) begin
        want_last = (got == LEDS - 1) ? 1'b1 : 1'b0;
        total++;
        if (pixel_o !== exp_pix[got] || pixel_last !== want_last) begin
          bad++;
          $display("FAIL %s pixel %0d: got %h last=%b want %h last=%b",
                   name, got, pixel_o, pixel_last, exp_pix[got], want_last);
        end
        got++;
        stalled = 1'b0;
      end else begin
        stalled   = 1'b1;
        held_o    = pixel_o;
        held_last = pixel_last;
      end
      @(posedge clk); #1;
      cycles++;
    end
    start       = 1'b0;
    pixel_ready = 1'b0;
    total++;
    if (got != LEDS) begin
      bad++;
      $display("FAIL %s accept count: got %0d want %0d", name, got, LEDS);
    end
    if (ready_pct >= 100) begin
      total++;
      if (cycles != LEDS) begin
        bad++;
        $display("FAIL %s contiguous cycles: got %0d want %0d", name, cycles, LEDS);
      end
    end
    total++;
    if ({pixel_v, frame_done, busy} !== 3'b011) begin
      bad++;
      $display("FAIL %s done cycle: {v,done,busy}=%b want 011", name, {pixel_v, frame_done, busy});
    end
    @(posedge clk); #1;
    total++;
    if ({pixel_v, frame_done, busy} !== 3'b000) begin
      bad++;
      $display("FAIL %s after done: {v,done,busy}=%b want 000", name, {pixel_v, frame_done, busy});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++;
    if ({pixel_v, pixel_last, frame_done, busy, pixel_o} !== 28'h0) begin
      bad++;
      $display("FAIL reset async: got %h want 0", {pixel_v, pixel_last, frame_done, busy, pixel_o});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({pixel_v, pixel_last, frame_done, busy, pixel_o} !== 28'h0) begin
      bad++;
      $display("FAIL reset idle: got %h want 0", {pixel_v, pixel_last, frame_done, busy, pixel_o});
    end
  endtask

  task automatic test_all_zero();
    for (int b = 0; b < BIN_QTY; b++) begin
      m_rgb[b] = 24'($urandom);
      m_cnt[b] = 0;
    end
    start_frame("all_zero");
    collect("all_zero", 100, -1);
  endtask

  task automatic setup_two_bins();
    for (int b = 0; b < BIN_QTY; b++) begin
      m_rgb[b] = 24'($urandom);
      m_cnt[b] = 0;
    end
    m_rgb[0] = 24'hFF0000; m_cnt[0] = 10;
    m_rgb[3] = 24'h00FF00; m_cnt[3] = 5;
  endtask

  task automatic test_two_bins();
    setup_two_bins();
    start_frame("two_bins");
    collect("two_bins", 100, -1);
  endtask

  task automatic test_truncation();
    for (int b = 0; b < BIN_QTY; b++) begin
      m_rgb[b] = 24'($urandom);
      m_cnt[b] = 5;
    end
    start_frame("truncation");
    collect("truncation", 100, -1);
  endtask

  task automatic test_random_stall();
    setup_two_bins();
    start_frame("stall_two_bins");
    collect("stall_two_bins", 50, -1);
    for (int f = 0; f < 6; f++) begin
      random_frame();
      start_frame("random_frame");
      collect("random_frame", 30 + 14 * f, -1);
    end
  endtask

  task automatic test_back_to_back();
    random_frame();
    start_frame("ignore_start");
    collect("ignore_start", 100, 20);
    random_frame();
    start_frame("back_to_back");
    collect("back_to_back", 70, -1);
  endtask

  task automatic test_reset_mid_frame();
    random_frame();
    start_frame("mid_reset");
    for (int i = 0; i < 20; i++) begin
      pixel_ready = 1'b1;
      total++;
      if (pixel_v !== 1'b1 || pixel_o !== exp_pix[i]) begin
        bad++;
        $display("FAIL mid_reset pixel %0d: got %h v=%b want %h v=1", i, pixel_o, pixel_v, exp_pix[i]);
      end
      @(posedge clk); #1;
    end
    pixel_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({pixel_v, pixel_last, frame_done, busy, pixel_o} !== 28'h0) begin
      bad++;
      $display("FAIL mid_reset async: got %h want 0", {pixel_v, pixel_last, frame_done, busy, pixel_o});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if ({pixel_v, frame_done, busy} !== 3'b000) begin
        bad++;
        $display("FAIL mid_reset idle: {v,done,busy}=%b want 000", {pixel_v, frame_done, busy});
      end
    end
    random_frame();
    start_frame("after_reset");
    collect("after_reset", 60, -1);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_all_zero();
    test_two_bins();
    test_truncation();
    test_random_stall();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
